sprite_blitter: RTL and testbench

Parametrised sprite draw engine for the VGA battle-screen path: on a `start` pulse, walks a W×H sprite stored in an external single-port ROM and emits one pixel per clock as `out_x`/`out_y`/`out_colour`, with a `plot` write strobe for the VGA adapter. Generalises the fixed-size per-sprite drawers with:
- parametrised dimensions and colour depth;
- start/busy/done handshake;
- transparent-colour skipping;
- horizontal mirroring;
- screen-edge clipping.

One instance serves every sprite; the sprite arbiter muxes ROMs onto `rom_address`/`rom_q`.

---
 rtl/vga_pkg.sv | 18 +
 rtl/sprite_scan_counter.sv | 62 ++++++
 rtl/sprite_blitter.sv | 136 +++++++++++++
 tb/tb_sprite_blitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA path definitions: screen defaults, coordinate widths and the
// sprite blitter state encoding.
package vga_pkg;

    localparam int unsigned SCREEN_W_DEF = 320;
    localparam int unsigned SCREEN_H_DEF = 240;
    localparam int unsigned X_W          = 9;
    localparam int unsigned Y_W          = 8;
    localparam int unsigned COLOUR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } blit_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major sprite walk: column/row counters, running row base (no multiplier)
// and the ROM address with optional horizontal mirroring.
module sprite_scan_counter
    import vga_pkg::*;
#(
    parameter int unsigned SPRITE_W = 63,
    parameter int unsigned SPRITE_H = 56,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned COL_W    = 6,
    parameter int unsigned ROW_W    = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic              i_mirror,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_last
);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_row_base;
    logic              w_col_end;
    logic [COL_W-1:0]  w_col_eff;

    assign w_col_end = (r_col == COL_W'(SPRITE_W - 1));
    assign o_last    = w_col_end && (r_row == ROW_W'(SPRITE_H - 1));
    assign w_col_eff = i_mirror ? (COL_W'(SPRITE_W - 1) - r_col) : r_col;

    // Counters wrap back to zero after the final pixel so the next draw starts clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (i_clear) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (i_advance) begin
            if (o_last) begin
                r_col      <= '0;
                r_row      <= '0;
                r_row_base <= '0;
            end else if (w_col_end) begin
                r_col      <= '0;
                r_row      <= r_row + ROW_W'(1);
                r_row_base <= r_row_base + ADDR_W'(SPRITE_W);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_address = r_row_base + ADDR_W'(w_col_eff);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite draw engine: walks a W x H ROM sprite one pixel per clock and emits
// clipped, transparency-keyed pixels with a plot strobe for the VGA adapter.
module sprite_blitter
    import vga_pkg::*;
#(
    parameter int unsigned SPRITE_W      = 63,
    parameter int unsigned SPRITE_H      = 56,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned COLOUR_W      = COLOUR_W_DEF,
    parameter int unsigned SCREEN_W      = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H      = SCREEN_H_DEF,
    parameter bit          TRANSP_EN     = 1'b1,
    parameter int unsigned TRANSP_COLOUR = 0
) (
    input  logic                clock_all,
    input  logic                reset_all,
    input  logic                start,
    input  logic [X_W-1:0]      x_,
    input  logic [Y_W-1:0]      y_,
    input  logic                mirror,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      out_x,
    output logic [Y_W-1:0]      out_y,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                plot
);

    localparam int unsigned COL_W = $clog2(SPRITE_W);
    localparam int unsigned ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    blit_state_t      r_state;
    blit_state_t      w_next;
    logic             r_busy;
    logic             r_done;
    logic [X_W-1:0]   r_x_lat;
    logic [Y_W-1:0]   r_y_lat;
    logic             r_mirror;
    logic             r_issued_d;
    logic [COL_W-1:0] r_col_d;
    logic [ROW_W-1:0] r_row_d;
    logic             w_accept;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last;
    logic [X_W:0]     w_sum_x;
    logic [Y_W:0]     w_sum_y;
    logic             w_transparent;

    assign w_accept = (r_state == IDLE) && start;

    sprite_scan_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_scan (
        .i_clk     (clock_all),
        .i_rst     (reset_all),
        .i_clear   (w_accept),
        .i_advance (r_state == RUN),
        .i_mirror  (r_mirror),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_address (rom_address),
        .o_last    (w_last)
    );

    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Draw origin and orientation are frozen for the whole draw.
    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            r_x_lat  <= '0;
            r_y_lat  <= '0;
            r_mirror <= 1'b0;
        end else if (w_accept) begin
            r_x_lat  <= x_;
            r_y_lat  <= y_;
            r_mirror <= mirror;
        end
    end

    // Pixel stage lines up screen coordinates with rom_q one cycle after issue.
    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            r_issued_d <= 1'b0;
            r_col_d    <= '0;
            r_row_d    <= '0;
        end else begin
            r_issued_d <= (r_state == RUN);
            r_col_d    <= w_col;
            r_row_d    <= w_row;
        end
    end

    assign w_sum_x       = (X_W+1)'(r_x_lat) + (X_W+1)'(r_col_d);
    assign w_sum_y       = (Y_W+1)'(r_y_lat) + (Y_W+1)'(r_row_d);
    assign w_transparent = TRANSP_EN && (rom_q == COLOUR_W'(TRANSP_COLOUR));

    // The extra sum bit keeps wrapped coordinates off screen.
    assign plot = r_issued_d && !w_transparent
               && (w_sum_x < (X_W+1)'(SCREEN_W))
               && (w_sum_y < (Y_W+1)'(SCREEN_H));

    assign out_x      = w_sum_x[X_W-1:0];
    assign out_y      = w_sum_y[Y_W-1:0];
    assign out_colour = rom_q;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a 4x3 instance for the functional draws
// and a default 63x56 instance (no transparency) for the full-size draw.
module tb_sprite_blitter;

    localparam int unsigned SW = 4;
    localparam int unsigned SH = 3;
    localparam int unsigned N  = SW * SH;
    localparam int unsigned BN = 63 * 56;

    typedef struct {
        int x;
        int y;
        int colour;
        int plot;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mirror;
    logic [8:0] x_in;
    logic [7:0] y_in;
    logic       busy, done, plot;
    logic [3:0] rom_addr;
    logic [2:0] rom_q;
    logic [8:0] out_x;
    logic [7:0] out_y;
    logic [2:0] out_col;

    logic        start_b;
    logic        busy_b, done_b, plot_b;
    logic [11:0] rom_addr_b;
    logic [2:0]  rom_q_b;
    logic [8:0]  out_x_b;
    logic [7:0]  out_y_b;
    logic [2:0]  out_col_b;

    int   total = 0;
    int   bad   = 0;
    int   aq[$];
    pix_t pq[$];

    always #5 clk = ~clk;

    sprite_blitter #(
        .SPRITE_W(4), .SPRITE_H(3), .ADDR_W(4), .COLOUR_W(3),
        .SCREEN_W(320), .SCREEN_H(240), .TRANSP_EN(1'b1), .TRANSP_COLOUR(0)
    ) dut (
        .clock_all(clk), .reset_all(rst), .start(start), .x_(x_in), .y_(y_in),
        .mirror(mirror), .busy(busy), .done(done), .rom_address(rom_addr),
        .rom_q(rom_q), .out_x(out_x), .out_y(out_y), .out_colour(out_col),
        .plot(plot)
    );

    sprite_blitter #(.TRANSP_EN(1'b0)) dut_big (
        .clock_all(clk), .reset_all(rst), .start(start_b), .x_(9'd0), .y_(8'd0),
        .mirror(1'b0), .busy(busy_b), .done(done_b), .rom_address(rom_addr_b),
        .rom_q(rom_q_b), .out_x(out_x_b), .out_y(out_y_b), .out_colour(out_col_b),
        .plot(plot_b)
    );

    // ROM models: colour = address mod 8, one cycle read latency.
    always @(posedge clk) begin
        rom_q   <= rom_addr[2:0];
        rom_q_b <= rom_addr_b[2:0];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int x, input int y, input bit m);
        pix_t p;
        int   a, sx, sy;
        for (int r = 0; r < int'(SH); r++) begin
            for (int c = 0; c < int'(SW); c++) begin
                a  = r * int'(SW) + (m ? (int'(SW) - 1 - c) : c);
                sx = x + c;
                sy = y + r;
                p.x      = sx % 512;
                p.y      = sy % 256;
                p.colour = a % 8;
                p.plot   = (p.colour != 0 && sx < 320 && sy < 240) ? 1 : 0;
                aq.push_back(a);
                pq.push_back(p);
            end
        end
    endtask

    // Start a draw and follow it cycle by cycle; optionally poke start
    // mid-run / in the DONE cycle, or reset after cycle rst_at.
    task automatic draw(input int x, input int y, input bit m,
                        input bit poke_mid, input bit poke_done, input int rst_at);
        pix_t p;
        int   a;
        push_expect(x, y, m);
        x_in   = 9'(x);
        y_in   = 8'(y);
        mirror = m;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= int'(N) + 1; k++) begin
            if (k < int'(N)) begin
                a = aq.pop_front();
                check("addr", int'(rom_addr), a);
            end
            if (k >= 1 && k <= int'(N)) begin
                p = pq.pop_front();
                check("out_x", int'(out_x), p.x);
                check("out_y", int'(out_y), p.y);
                check("colour", int'(out_col), p.colour);
                check("plot", int'(plot), p.plot);
            end else begin
                check("plot_window", int'(plot), 0);
            end
            check("busy", int'(busy), 1);
            check("done", int'(done), (k == int'(N) + 1) ? 1 : 0);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_plot", int'(plot), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                #1;
                rst = 1'b0;
                aq.delete();
                pq.delete();
                tick();
                check("rst_idle_done", int'(done), 0);
                check("rst_idle_busy", int'(busy), 0);
                return;
            end
            if (poke_mid && k == 4) begin
                start  = 1'b1;
                x_in   = 9'd100;
                mirror = ~m;
            end else if (poke_done && k == int'(N) + 1) begin
                start = 1'b1;
                x_in  = 9'd200;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("busy_after", int'(busy), 0);
        check("done_after", int'(done), 0);
    endtask

    initial begin
        int plots, edges, max_addr;
        bit seen;
        rst     = 1'b1;
        start   = 1'b0;
        start_b = 1'b0;
        mirror  = 1'b0;
        x_in    = '0;
        y_in    = '0;
        tick();
        tick();
        check("rst_busy0", int'(busy), 0);
        check("rst_done0", int'(done), 0);
        check("rst_plot0", int'(plot), 0);
        check("rst_addr0", int'(rom_addr), 0);
        check("rst_x0", int'(out_x), 0);
        check("rst_y0", int'(out_y), 0);
        rst = 1'b0;
        tick();

        draw(10, 20, 1'b0, 1'b0, 1'b0, -1);
        draw(10, 20, 1'b1, 1'b0, 1'b0, -1);
        draw(318, 239, 1'b1, 1'b0, 1'b0, -1);
        draw(318, 239, 1'b0, 1'b0, 1'b0, -1);
        draw(509, 254, 1'b0, 1'b0, 1'b0, -1);
        draw(10, 20, 1'b0, 1'b1, 1'b1, -1);
        draw(40, 50, 1'b1, 1'b0, 1'b0, -1);
        draw(10, 20, 1'b0, 1'b0, 1'b0, 6);
        draw(10, 20, 1'b0, 1'b0, 1'b0, -1);

        start_b = 1'b1;
        tick();
        start_b  = 1'b0;
        plots    = 0;
        edges    = 0;
        max_addr = -1;
        seen     = 1'b0;
        while (!seen && edges < 5000) begin
            if (plot_b) plots++;
            if (busy_b && int'(rom_addr_b) > max_addr) max_addr = int'(rom_addr_b);
            if (done_b) seen = 1'b1;
            else begin
                tick();
                edges++;
            end
        end
        check("big_done_seen", int'(seen), 1);
        check("big_cycles", edges, int'(BN) + 1);
        check("big_plots", plots, int'(BN));
        check("big_last_addr", max_addr, int'(BN) - 1);
        tick();
        check("big_busy_after", int'(busy_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
